// File: rtl/sipo_pkg.sv
// Shared types and helpers for the framed serial-in/parallel-out deserialiser.
package sipo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } sipo_state_e;

  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

  // Counter must hold 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Per-frame bit counter: clear wins over increment, optional saturation at WIDTH.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  input  logic          sat_en,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [CW-1:0] count_q, count_d;

  assign full  = (count_q == CW'(WIDTH));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && !(full && sat_en))
      count_d = full ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/sipo_framed_shiftreg.sv
// Serial-to-parallel deserialiser with frame counting, auto/manual latch,
// valid/ack handshake and sticky overrun.
module sipo_framed_shiftreg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SI,
  input  logic             shift_en,
  input  logic             latch,
  input  logic             auto_mode,
  input  logic             frame_sync,
  input  logic             po_ack,
  output logic [WIDTH-1:0] PO,
  output logic             po_valid,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  sipo_state_e      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_next;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             overrun_q, overrun_d;
  logic             cnt_full, complete, latch_fire, cnt_clr;

  sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (shift_en),
    .clr    (cnt_clr),
    .sat_en (1'b1),
    .count  (bit_cnt),
    .full   (cnt_full)
  );

  assign complete   = shift_en && (state_q == FILL) && (bit_cnt == CW'(WIDTH - 1));
  assign latch_fire = latch || (auto_mode && complete);
  assign cnt_clr    = latch_fire || frame_sync;

  always_comb begin
    sr_next = sr_q;
    if (shift_en) begin
      if (MSB_FIRST[0] == MSB_FIRST_ORDER) sr_next = {sr_q[WIDTH-2:0], SI};
      else                                 sr_next = {SI, sr_q[WIDTH-1:1]};
    end
    // Latch samples sr_next before frame_sync wipes the register.
    sr_d       = frame_sync ? '0 : sr_next;
    po_d       = latch_fire ? sr_next : po_q;
    po_valid_d = latch_fire ? 1'b1 : (po_ack ? 1'b0 : po_valid_q);
    overrun_d  = overrun_q || (latch_fire && po_valid_q && !po_ack);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (shift_en && !cnt_clr && !cnt_full) state_d = FILL;
      FILL: if (cnt_clr || complete)               state_d = IDLE;
      default:                                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign PO       = po_q;
  assign po_valid = po_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: doc/sipo_framed_shiftreg.md
# sipo_framed_shiftreg

Parametrised serial-in/parallel-out deserialiser; successor to the fixed 8-bit SIPO shift register. Shifts a serial bit stream into a WIDTH-bit register under a shift enable, counts bits per frame and presents each completed word on a registered parallel port with a valid/ack handshake. Supports automatic per-frame latching or manual latching, MSB- or LSB-first ordering, frame resync and overrun detection. Sits between a serial link front end and word-oriented downstream logic.

## Interface
- WIDTH, 8: parallel word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit ends in po[WIDTH-1]; 0 = first received bit ends in po[0].
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- SI  in  1  serial data bit.
- shift_en  in  1  SI is sampled and shifted in on this edge.
- latch  in  1  manual latch request (honoured in both modes).
- auto_mode  in  1  1 = latch automatically when WIDTH bits are received.
- frame_sync  in  1  discard the partial frame; bit count restarts at 0.
- po_ack  in  1  consumer accepts the current word.
- PO  out  WIDTH  latched parallel word.
- po_valid  out  1  PO holds an unaccepted word.
- bit_cnt  out  $clog2(WIDTH+1)  bits received in the current frame.
- overrun  out  1  sticky: a word was overwritten before being acknowledged.

## Operation
- Reset: the shift register, PO, po_valid, bit_cnt and overrun all go to 0. Reset overrides all other inputs, including mid-frame.
- Shift: when shift_en=1, MSB_FIRST=1 does sr <= {sr[WIDTH-2:0], SI}; MSB_FIRST=0 does sr <= {SI, sr[WIDTH-1:1]}. bit_cnt increments.
- State machine (in the package): IDLE (bit_cnt=0) and FILL (0<bit_cnt<WIDTH). IDLE goes to FILL on shift_en. FILL goes to IDLE on frame completion, latch, or frame_sync.
- Frame completion: the shift that makes bit_cnt reach WIDTH. If auto_mode=1, PO <= next sr, po_valid <= 1 and bit_cnt <= 0 on that same edge. If auto_mode=0, bit_cnt saturates at WIDTH and further shifts keep shifting (oldest bits are lost) until latch.
- Manual latch: PO <= next sr (including any bit shifted that same cycle), zero-extended per current contents, with no masking of partial frames. Then po_valid <= 1, bit_cnt <= 0, and sr is kept.
- frame_sync: bit_cnt <= 0 and sr <= 0. It has priority over shift_en. If latch or auto-completion happens in the same cycle, the latch takes effect first and uses the pre-clear next sr.
- Handshake: po_valid stays high until an edge with po_ack=1 and no new latch, then clears. po_ack while po_valid=0 is ignored.
- Overrun: a new latch while po_valid=1 and po_ack=0 sets overrun; the new word overwrites PO. A latch with po_ack=1 in the same cycle is a clean hand-off: po_valid stays 1 and overrun is not set. overrun clears only on rst.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: the WIDTH-th bit sampled at edge N is visible on PO, with po_valid=1, immediately after edge N.
- Back-to-back frames: continuous shift_en gives one po_valid word every WIDTH cycles with zero gap cycles.
- bit_cnt updates on the same edge as the shift.

## Structure
- Package sipo_pkg holds:
  - the state enum (IDLE, FILL);
  - the MSB_FIRST/LSB_FIRST constants;
  - a function returning the counter width from WIDTH.
- Sub-module sipo_bit_counter:
  - ports: clk, rst, inc, clr, sat_en, count, full;
  - it is the only natural split;
  - the shift register, latch and handshake logic stay in the top module.

## Test plan
- WIDTH=8, MSB_FIRST=1, auto_mode=1: shift 1,0,1,0,0,1,0,1 -> PO=0xA5 and po_valid=1 after edge 8, bit_cnt=0.
- MSB_FIRST=0, same bit sequence -> PO=0xA5 reversed = 0xA5 (palindrome check excluded); use 1,1,0,0,0,0,0,0 -> PO=0x03.
- auto_mode=0: shift 1,1,0, then latch -> PO=0x06, po_valid=1, bit_cnt=0. Continue with 5 more shifts and no latch -> bit_cnt stays at 5 and PO is unchanged.
- Overrun: two consecutive auto frames 0xFF then 0x0F with po_ack held 0 -> PO=0x0F, overrun=1. Repeat with po_ack=1 on the second completion edge -> overrun=0.
- Reset mid-frame after 4 bits -> all outputs 0. A following 8-bit frame 0x3C latches correctly.
- frame_sync after 3 bits, then 8 bits of 0x81 -> PO=0x81, with no stale bits.
